// File: rtl/ni_inject_pkg.sv
// noc_ni_pkg: shared flit types, HEAD field slots, FSM states and credit sizing for the NI injection stage
package noc_ni_pkg;
  localparam logic [1:0] FT_IDLE = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;
  localparam int HF_DSTX = 0;
  localparam int HF_DSTY = 1;
  localparam int HF_SRCX = 2;
  localparam int HF_SRCY = 3;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;
  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/ni_inject_if.sv
// ni_inject_if: core word stream plus router local-port link seen by the injection stage
interface ni_inject_if #(
  parameter int NVCH   = 2,
  parameter int VCHW   = 1,
  parameter int ARRAYW = 4,
  parameter int DATAW  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATAW-1:0]  in_data;
  logic              in_last;
  logic [ARRAYW-1:0] in_dst_x;
  logic [ARRAYW-1:0] in_dst_y;
  logic [DATAW+1:0]  odata;
  logic              ovalid;
  logic [VCHW-1:0]   ovch;
  logic [NVCH-1:0]   iack;
  logic [NVCH-1:0]   ilck;
  modport master (
    output in_valid, in_data, in_last, in_dst_x, in_dst_y, iack, ilck,
    input  in_ready, odata, ovalid, ovch
  );
  modport slave (
    input  in_valid, in_data, in_last, in_dst_x, in_dst_y, iack, ilck,
    output in_ready, odata, ovalid, ovch
  );
endinterface

// File: rtl/ni_inject_credit_ctr.sv
// ni_credit_ctr: per-VC credit counter; saturates at DEPTH and flags a sticky overflow on a surplus ack
module ni_credit_ctr
  import noc_ni_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = cred_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          nonzero,
  output logic          ovf
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic surplus;
  assign surplus = inc && !dec && count == FULL;
  assign nonzero = |count;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= FULL;
      ovf   <= 1'b0;
    end else begin
      count <= surplus ? count : count + CW'(inc) - CW'(dec);
      ovf   <= ovf | surplus;
    end
  end
endmodule

// File: rtl/ni_inject.sv
// ni_inject: builds HEAD from destination coordinates and injects HEAD/BODY/TAIL flits into router port 4 under per-VC credit
module ni_inject
  import noc_ni_pkg::*;
#(
  parameter int NVCH      = 2,
  parameter int VCHW      = 1,
  parameter int BUF_DEPTH = 4,
  parameter int ARRAYW    = 4,
  parameter int DATAW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ARRAYW-1:0] my_xpos,
  input  logic [ARRAYW-1:0] my_ypos,
  ni_inject_if.slave        bus,
  output logic              err
);
  localparam int CW = cred_w(BUF_DEPTH);
  logic [0:0]       state;
  logic [VCHW-1:0]  cur_vc;
  logic [VCHW-1:0]  sel;
  logic [NVCH-1:0]  nz;
  logic [NVCH-1:0]  ovf;
  logic [NVCH-1:0]  dec;
  logic [NVCH-1:0]  free;
  logic [DATAW-1:0] head;
  logic             send_head;
  logic             accept;
  assign free         = ~bus.ilck & nz;
  assign bus.in_ready = state == ST_SEND && nz[cur_vc];
  assign send_head    = state == ST_IDLE && bus.in_valid && |free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign err          = |ovf;
  always_comb begin
    sel = '0;
    for (int i = NVCH - 1; i >= 0; i--)
      if (free[i]) sel = VCHW'(i);
  end
  always_comb begin
    head = '0;
    head[HF_DSTX*ARRAYW +: ARRAYW] = bus.in_dst_x;
    head[HF_DSTY*ARRAYW +: ARRAYW] = bus.in_dst_y;
    head[HF_SRCX*ARRAYW +: ARRAYW] = my_xpos;
    head[HF_SRCY*ARRAYW +: ARRAYW] = my_ypos;
  end
  for (genvar v = 0; v < NVCH; v++) begin : g_cc
    logic [CW-1:0] count;
    assign dec[v] = (send_head && sel == VCHW'(v)) || (accept && cur_vc == VCHW'(v));
    ni_credit_ctr #(.DEPTH(BUF_DEPTH)) u_cc (
      .clk(clk), .rst(rst), .inc(bus.iack[v]), .dec(dec[v]),
      .count(count), .nonzero(nz[v]), .ovf(ovf[v])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_vc     <= '0;
      bus.ovalid <= 1'b0;
      bus.odata  <= '0;
      bus.ovch   <= '0;
    end else begin
      bus.ovalid <= send_head || accept;
      if (send_head) begin
        cur_vc    <= sel;
        bus.ovch  <= sel;
        bus.odata <= {FT_HEAD, head};
        state     <= ST_SEND;
      end else if (accept) begin
        bus.ovch  <= cur_vc;
        bus.odata <= {bus.in_last ? FT_TAIL : FT_BODY, bus.in_data};
        if (bus.in_last) state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ni_inject.sv
// tb_ni_inject: directed packets with a timed flit scoreboard for ni_inject
module tb_ni_inject;
  import noc_ni_pkg::*;
  typedef struct {int vc; logic [33:0] d; int t;} exp_t;
  logic clk = 0;
  logic rst = 1;
  logic [3:0] my_xpos = 0;
  logic [3:0] my_ypos = 0;
  logic err;
  logic auto_ack = 0;
  logic [1:0] man_ack = 0;
  int cyc = 0;
  int vec = 0;
  int bad = 0;
  exp_t q[$];
  ni_inject_if #(.NVCH(2), .VCHW(1), .ARRAYW(4), .DATAW(32)) intf ();
  ni_inject #(.NVCH(2), .VCHW(1), .BUF_DEPTH(4), .ARRAYW(4), .DATAW(32)) dut (
    .clk(clk), .rst(rst), .my_xpos(my_xpos), .my_ypos(my_ypos), .bus(intf.slave), .err(err)
  );
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(posedge clk);
    #2;
    intf.iack = (auto_ack && intf.ovalid) ? 2'(1 << intf.ovch) : man_ack;
  end
  initial forever begin
    @(negedge clk);
    if (intf.ovalid) begin
      vec++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL flit: unexpected flit %h vc %0d at cycle %0d", intf.odata, intf.ovch, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (intf.odata !== e.d || int'(intf.ovch) != e.vc || cyc != e.t) begin
          bad++;
          $display("FAIL flit: got %h vc %0d cycle %0d, want %h vc %0d cycle %0d",
                   intf.odata, intf.ovch, cyc, e.d, e.vc, e.t);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic push(input int vc, input logic [33:0] d);
    q.push_back('{vc, d, cyc + 1});
  endtask
  task automatic wait_rdy;
    int n = 0;
    while (!intf.in_ready && n < 50) begin
      tick;
      n++;
    end
    chk("in_ready wait", {63'd0, intf.in_ready}, 64'd1);
  endtask
  task automatic chk_credits(input string nm);
    chk({nm, " credit0"}, 64'(dut.g_cc[0].count), 64'd4);
    chk({nm, " credit1"}, 64'(dut.g_cc[1].count), 64'd4);
  endtask
  task automatic pkt(input logic [3:0] dx, input logic [3:0] dy, input int vc, input int n,
                     input logic [31:0] base, input logic [33:0] hexp);
    intf.in_dst_x = dx;
    intf.in_dst_y = dy;
    intf.in_data  = base;
    intf.in_last  = n == 1;
    intf.in_valid = 1;
    push(vc, hexp);
    for (int i = 0; i < n; i++) begin
      tick;
      wait_rdy;
      intf.in_data = base + 32'(i);
      intf.in_last = i == n - 1;
      push(vc, {i == n - 1 ? FT_TAIL : FT_BODY, base + 32'(i)});
    end
    tick;
    intf.in_valid = 0;
    intf.in_last  = 0;
  endtask
  initial begin
    intf.in_valid = 0;
    intf.in_data  = 0;
    intf.in_last  = 0;
    intf.in_dst_x = 0;
    intf.in_dst_y = 0;
    intf.ilck     = 0;
    repeat (2) tick;
    rst = 0;
    chk("reset ovalid", {63'd0, intf.ovalid}, 64'd0);
    chk("reset in_ready", {63'd0, intf.in_ready}, 64'd0);
    chk("reset err", {63'd0, err}, 64'd0);
    chk("reset odata", 64'(intf.odata), 64'd0);
    chk_credits("reset");
    tick;
    auto_ack = 1;
    pkt(4'd2, 4'd1, 0, 3, 32'hA, 34'h1_0000_0012);
    repeat (3) tick;
    chk_credits("after ack+send");
    chk("err after ack+send", {63'd0, err}, 64'd0);
    auto_ack = 0;
    fork
      pkt(4'd1, 4'd1, 0, 6, 32'h20, 34'h1_0000_0011);
      begin
        repeat (8) tick;
        chk("stall in_ready", {63'd0, intf.in_ready}, 64'd0);
        man_ack = 2'b01;
        tick;
        man_ack = 2'b00;
        repeat (4) tick;
        chk("stall again in_ready", {63'd0, intf.in_ready}, 64'd0);
        chk("stall credit0", 64'(dut.g_cc[0].count), 64'd0);
        man_ack = 2'b01;
        repeat (6) tick;
        man_ack = 2'b00;
      end
    join
    repeat (3) tick;
    chk_credits("after stall");
    auto_ack = 1;
    my_xpos = 4'd3;
    my_ypos = 4'd5;
    intf.ilck = 2'b01;
    pkt(4'd1, 4'd2, 1, 2, 32'h100, 34'h1_0000_5321);
    repeat (3) tick;
    intf.ilck = 2'b11;
    intf.in_dst_x = 4'd4;
    intf.in_dst_y = 4'd6;
    intf.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("all locked in_ready", {63'd0, intf.in_ready}, 64'd0);
    end
    intf.ilck = 2'b01;
    pkt(4'd4, 4'd6, 1, 1, 32'h200, 34'h1_0000_5364);
    repeat (3) tick;
    intf.ilck = 2'b00;
    auto_ack = 0;
    man_ack = 2'b10;
    tick;
    man_ack = 2'b00;
    repeat (2) tick;
    chk("overflow err", {63'd0, err}, 64'd1);
    chk("overflow credit1", 64'(dut.g_cc[1].count), 64'd4);
    repeat (3) tick;
    chk("sticky err", {63'd0, err}, 64'd1);
    my_xpos = 4'd0;
    my_ypos = 4'd0;
    auto_ack = 1;
    intf.in_dst_x = 4'd2;
    intf.in_dst_y = 4'd1;
    intf.in_data  = 32'h30;
    intf.in_valid = 1;
    push(0, 34'h1_0000_0012);
    tick;
    wait_rdy;
    push(0, {FT_BODY, 32'h30});
    tick;
    wait_rdy;
    intf.in_data = 32'h31;
    push(0, {FT_BODY, 32'h31});
    tick;
    rst = 1;
    intf.in_valid = 0;
    tick;
    rst = 0;
    chk("midreset ovalid", {63'd0, intf.ovalid}, 64'd0);
    chk("midreset in_ready", {63'd0, intf.in_ready}, 64'd0);
    chk("midreset err", {63'd0, err}, 64'd0);
    chk_credits("midreset");
    pkt(4'd2, 4'd1, 0, 2, 32'h40, 34'h1_0000_0012);
    repeat (5) tick;
    chk("pending flits", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
